cache_switch_ctrl: RTL and testbench
====================================

// Module: cache_switch_ctrl
// PURPOSE
// Executes the custom cache-switch instruction (opcode 7'b1111111) once the decoder flags it.
// Freezes the pipeline and waits for the data cache to go idle.
// Optionally writes back and invalidates the target bank, then retargets the data cache.
// Sits between the decoder/ID-EX stage and the data cache bank select.
// PARAMETERS
// NUM_BANKS  2  number of data cache banks (one per process context)
// BANK_W     1  width of bank index, = $clog2(NUM_BANKS), min 1
// NUM_LINES  8  lines per bank to scan on a flushing switch
// IDX_W      3  width of line index, = $clog2(NUM_LINES)
// PORTS
// clk            in   1       system clock, all state updates on rising edge
// reset          in   1       synchronous, active-high
// switch_cache_w in   1       decoded switch request, valid for one cycle
// switch_bank    in   BANK_W  target bank, valid with switch_cache_w
// switch_flush   in   1       fun_3[2] of the instruction: 1 = write back and invalidate target first
// cache_busy     in   1       data cache has an outstanding miss/write
// line_dirty     in   1       dirty bit of line scan_idx in bank scan_bank, same-cycle combinational
// wb_ack         in   1       one-cycle pulse: write-back of the requested line complete
// stall          out  1       freeze PC and pipeline registers
// active_bank    out  BANK_W  bank select driven to data cache
// scan_bank      out  BANK_W  bank being scanned/invalidated (latched target)
// scan_idx       out  IDX_W   line under scan
// wb_req         out  1       write back line scan_idx of scan_bank
// inval_bank     out  1       one-cycle pulse: clear valid+dirty of every line in scan_bank
// switch_done    out  1       one-cycle pulse: switch completed
// bad_target     out  1       one-cycle pulse (registered): request ignored, switch_bank >= NUM_BANKS
// BEHAVIOUR
// Reset: state IDLE; active_bank=0; scan_bank=0; scan_idx=0; tgt/flush latches 0; bad_target=0.
//   All Moore outputs are 0 in IDLE.
// stall = (state!=IDLE) | (switch_cache_w & legal), where legal = switch_bank < NUM_BANKS.
//   Combinational, so the request cycle is already frozen.
// IDLE:
//   switch_cache_w & legal  -> latch target into scan_bank, latch switch_flush; go to DRAIN.
//   switch_cache_w & !legal -> bad_target=1 next cycle; stay IDLE; active_bank unchanged.
// DRAIN:
//   stay while cache_busy=1.
//   Otherwise go to SCAN (flush=1, scan_idx<=0) or to SWITCH (flush=0).
// SCAN:
//   line_dirty=1 -> WB.
//   line_dirty=0 and scan_idx==NUM_LINES-1 -> INVAL.
//   Otherwise scan_idx++.
// WB:
//   wb_req=1 with scan_idx held stable until wb_ack.
//   On wb_ack: last line -> INVAL; otherwise scan_idx++ and go to SCAN.
// INVAL: inval_bank=1 for exactly one cycle -> SWITCH.
// SWITCH:
//   active_bank<=scan_bank at exit edge; switch_done=1 -> IDLE.
//   stall drops the cycle after SWITCH.
// Latency, flush=0 and cache_busy=0: stall high 3 cycles (request, DRAIN, SWITCH).
//   New active_bank is visible on the first unstalled cycle.
// Flush latency: 3 + NUM_LINES scan cycles + 1 INVAL + write-back wait cycles.
// scan_idx never wraps. The terminal test is scan_idx==NUM_LINES-1, and the counter stops there.
// Boundary rules:
//   target==active_bank: full sequence still runs; active_bank value unchanged; done still pulses.
//   switch_cache_w while not IDLE: ignored (pipeline is frozen; no queueing).
//   wb_ack outside WB: ignored.
//   wb_ack in the same cycle wb_req first rises: accepted.
//   reset mid-sequence: return to IDLE immediately and drop wb_req. active_bank=0.
//     A late wb_ack after reset is ignored.
//   cache_busy rising during SCAN/WB: no effect. The cache must arbitrate write-backs itself.
// STRUCTURE
// cache_switch_defs.vh:
//   state localparams IDLE/DRAIN/SCAN/WB/INVAL/SWITCH (3-bit).
//   SWITCH_OPCODE 7'b1111111.
//   SWITCH_FLUSH_BIT 2.
// Shared include for the decoder and this block.
// One sub-module: line_scan_counter (clear, enable, terminal flag at NUM_LINES-1, saturating).
// FSM, latches and output decode live in cache_switch_ctrl.
// TESTING
// 1. Reset, then request bank 1 with flush=0 and busy=0.
//    -> stall high exactly 3 cycles; active_bank=1; switch_done pulses once.
// 2. Request with cache_busy held 4 cycles.
//    -> remains in DRAIN 4 cycles; stall high 7 cycles total; no wb_req.
// 3. Flush switch to bank 0, lines 2 and 5 dirty, wb_ack 3 cycles after each wb_req.
//    -> wb_req with scan_idx=2 then 5, each held until ack.
//    -> one inval_bank pulse, then switch_done; active_bank=0.
// 4. Flush with no dirty lines.
//    -> 8 SCAN cycles, no wb_req, inval_bank then done; stall high 12 cycles.
// 5. NUM_BANKS=3, request switch_bank=3.
//    -> stall never asserted; bad_target pulses 1 cycle; active_bank unchanged.
// 6. Reset asserted while in WB; spurious wb_ack next cycle.
//    -> IDLE, wb_req=0, active_bank=0, stall=0; ack ignored.

Source files
------------

// File: rtl/cache_switch_ctrl_pkg.sv
// Shared definitions for the cache-switch instruction: FSM encodings and decode constants.
// The decoder imports this too, so opcode and flush-bit position live here.
package cache_switch_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t DRAIN  = 3'd1;
  localparam state_t SCAN   = 3'd2;
  localparam state_t WB     = 3'd3;
  localparam state_t INVAL  = 3'd4;
  localparam state_t SWITCH = 3'd5;

  localparam logic [6:0] SWITCH_OPCODE    = 7'b1111111;
  localparam int         SWITCH_FLUSH_BIT = 2;

endpackage

// File: rtl/cache_switch_ctrl_if.sv
// Bundle between decoder/data cache and the cache-switch controller.
// The slave modport is the controller's view; master is the surrounding pipeline/cache.
interface cache_switch_ctrl_if #(
  parameter int BANK_W = 1,
  parameter int IDX_W  = 3
);
  logic              switch_cache_w;
  logic [BANK_W-1:0] switch_bank;
  logic              switch_flush;
  logic              cache_busy;
  logic              line_dirty;
  logic              wb_ack;
  logic              stall;
  logic [BANK_W-1:0] active_bank;
  logic [BANK_W-1:0] scan_bank;
  logic [IDX_W-1:0]  scan_idx;
  logic              wb_req;
  logic              inval_bank;
  logic              switch_done;
  logic              bad_target;

  modport slave (
    input  switch_cache_w, switch_bank, switch_flush, cache_busy, line_dirty, wb_ack,
    output stall, active_bank, scan_bank, scan_idx, wb_req, inval_bank, switch_done, bad_target
  );

  modport master (
    output switch_cache_w, switch_bank, switch_flush, cache_busy, line_dirty, wb_ack,
    input  stall, active_bank, scan_bank, scan_idx, wb_req, inval_bank, switch_done, bad_target
  );
endinterface

// File: rtl/cache_switch_ctrl_line_scan_counter.sv
// Line index walked during a flushing switch; saturates at the last line so it never wraps.
module line_scan_counter #(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] idx,
  output logic             terminal
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LINES - 1);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clear)
      idx_d = '0;
    else if (enable && (idx_q != LAST))
      idx_d = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  assign idx      = idx_q;
  assign terminal = (idx_q == LAST);
endmodule

// File: rtl/cache_switch_ctrl.sv
// Cache-switch instruction sequencer: freeze, drain, optional write-back/invalidate of the
// target bank, then retarget the data cache bank select.
module cache_switch_ctrl
  import cache_switch_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1,
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3
) (
  input logic               clk,
  input logic               reset,
  cache_switch_ctrl_if.slave bus
);
  state_t            state_q, state_d;
  logic [BANK_W-1:0] active_bank_q, active_bank_d;
  logic [BANK_W-1:0] scan_bank_q, scan_bank_d;
  logic              flush_q, flush_d;
  logic              bad_target_q, bad_target_d;
  logic              cnt_clear, cnt_en, cnt_term;
  logic [IDX_W-1:0]  cnt_idx;
  logic              legal;

  // Extra MSB keeps the compare meaningful when NUM_BANKS is a power of two.
  assign legal = ({1'b0, bus.switch_bank} < (BANK_W + 1)'(NUM_BANKS));

  line_scan_counter #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_scan_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .idx      (cnt_idx),
    .terminal (cnt_term)
  );

  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    scan_bank_d   = scan_bank_q;
    flush_d       = flush_q;
    bad_target_d  = 1'b0;
    cnt_clear     = 1'b1;
    cnt_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.switch_cache_w) begin
          if (legal) begin
            scan_bank_d = bus.switch_bank;
            flush_d     = bus.switch_flush;
            state_d     = DRAIN;
          end else begin
            bad_target_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!bus.cache_busy) state_d = flush_q ? SCAN : SWITCH;
      end
      SCAN: begin
        cnt_clear = 1'b0;
        if (bus.line_dirty)  state_d = WB;
        else if (cnt_term)   state_d = INVAL;
        else                 cnt_en  = 1'b1;
      end
      WB: begin
        // Index is held until the cache acknowledges the write-back of this line.
        cnt_clear = 1'b0;
        if (bus.wb_ack) begin
          if (cnt_term) begin
            state_d = INVAL;
          end else begin
            cnt_en  = 1'b1;
            state_d = SCAN;
          end
        end
      end
      INVAL:  state_d = SWITCH;
      SWITCH: begin
        active_bank_d = scan_bank_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      active_bank_q <= '0;
      scan_bank_q   <= '0;
      flush_q       <= 1'b0;
      bad_target_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      scan_bank_q   <= scan_bank_d;
      flush_q       <= flush_d;
      bad_target_q  <= bad_target_d;
    end
  end

  // The request cycle itself must already freeze the pipeline, hence the combinational term.
  assign bus.stall       = (state_q != IDLE) | (bus.switch_cache_w & legal);
  assign bus.active_bank = active_bank_q;
  assign bus.scan_bank   = scan_bank_q;
  assign bus.scan_idx    = cnt_idx;
  assign bus.wb_req      = (state_q == WB);
  assign bus.inval_bank  = (state_q == INVAL);
  assign bus.switch_done = (state_q == SWITCH);
  assign bus.bad_target  = bad_target_q;
endmodule

// File: tb/tb_cache_switch_ctrl.sv
// Bench for cache_switch_ctrl: scenario tasks plus randomized switches against a cycle-count model.
module tb_cache_switch_ctrl;
  localparam int NUM_LINES = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_switch_ctrl_if #(.BANK_W(1), .IDX_W(3)) a ();
  cache_switch_ctrl_if #(.BANK_W(2), .IDX_W(3)) b ();

  cache_switch_ctrl #(.NUM_BANKS(2), .BANK_W(1), .NUM_LINES(8), .IDX_W(3)) dut_a (
    .clk (clk), .reset (reset), .bus (a)
  );
  cache_switch_ctrl #(.NUM_BANKS(3), .BANK_W(2), .NUM_LINES(8), .IDX_W(3)) dut_b (
    .clk (clk), .reset (reset), .bus (b)
  );

  logic [NUM_LINES-1:0] dirty_a = '0;
  assign a.line_dirty = dirty_a[a.scan_idx];
  assign b.line_dirty = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int   obs_stall, obs_inval, obs_done, obs_unstable, obs_timeout, obs_bad_bank;
  int   obs_wb[$];
  int   exp_wb[$];
  logic obs_active;
  int   model_active = 0;

  // Expected stall length from the switch rules: request + DRAIN + SWITCH, plus the flush walk.
  function automatic int model_switch(input logic flush, input int busy_n,
                                      input logic [NUM_LINES-1:0] d, input int ackd);
    int n;
    exp_wb.delete();
    n = 3 + busy_n;
    if (flush) begin
      n += NUM_LINES + 1;
      for (int i = 0; i < NUM_LINES; i++)
        if (d[i]) begin
          exp_wb.push_back(i);
          n += ackd + 1;
        end
    end
    return n;
  endfunction

  task automatic run_switch(input logic bank, input logic flush, input int busy_n,
                            input logic [NUM_LINES-1:0] d, input int ackd, input logic spur);
    int wcnt;
    logic prev_wb, fin;
    logic [2:0] rise_idx;
    obs_stall = 0; obs_inval = 0; obs_done = 0; obs_unstable = 0;
    obs_timeout = 0; obs_bad_bank = 0; obs_wb.delete();
    dirty_a = d;
    wcnt = 0; prev_wb = 1'b0; fin = 1'b0; rise_idx = '0;
    @(posedge clk); #1;
    a.switch_cache_w = 1'b1; a.switch_bank = bank; a.switch_flush = flush;
    a.cache_busy = 1'b0; a.wb_ack = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        a.switch_cache_w = spur && (cyc == 1);
        a.switch_bank    = (spur && (cyc == 1)) ? ~bank : bank;
        a.cache_busy     = (cyc <= busy_n);
        a.wb_ack         = spur && (cyc == 1);
        if (a.wb_req) begin
          if (wcnt == ackd) a.wb_ack = 1'b1;
          wcnt++;
        end else begin
          wcnt = 0;
        end
      end
      @(negedge clk);
      if (a.stall) begin
        obs_stall++;
        if (a.wb_req && !prev_wb) begin
          obs_wb.push_back(int'(a.scan_idx));
          rise_idx = a.scan_idx;
        end
        if (a.wb_req && prev_wb && (a.scan_idx != rise_idx)) obs_unstable++;
        prev_wb = a.wb_req;
        if (a.inval_bank) begin
          obs_inval++;
          if (a.scan_bank !== bank) obs_bad_bank++;
        end
        if (a.switch_done) obs_done++;
      end else if (cyc > 0) begin
        fin = 1'b1;
        obs_active = a.active_bank;
      end
    end
    if (!fin) obs_timeout = 1;
    a.switch_cache_w = 1'b0; a.cache_busy = 1'b0; a.wb_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (a.stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b expected 0", a.stall); end
    n_checks++; if (a.active_bank !== 1'b0) begin n_errors++; $display("FAIL reset_active: got %0d expected 0", a.active_bank); end
    n_checks++; if ({a.scan_bank, a.scan_idx} !== 4'd0) begin n_errors++; $display("FAIL reset_scan: got bank %0d idx %0d expected 0 0", a.scan_bank, a.scan_idx); end
    n_checks++; if ({a.wb_req, a.inval_bank, a.switch_done, a.bad_target} !== 4'b0) begin n_errors++; $display("FAIL reset_pulses: got %b expected 0000", {a.wb_req, a.inval_bank, a.switch_done, a.bad_target}); end
    n_checks++; if ({b.stall, b.active_bank, b.bad_target} !== 4'b0) begin n_errors++; $display("FAIL reset_b: got %b expected 0000", {b.stall, b.active_bank, b.bad_target}); end
    model_active = 0;
  endtask

  task automatic test_no_flush;
    int es;
    es = model_switch(1'b0, 0, '0, 0);
    run_switch(1'b1, 1'b0, 0, '0, 0, 1'b0);
    model_active = 1;
    n_checks++; if (obs_stall != es) begin n_errors++; $display("FAIL noflush_stall: got %0d cycles expected %0d", obs_stall, es); end
    n_checks++; if (obs_active !== 1'b1) begin n_errors++; $display("FAIL noflush_active: got %0d expected 1", obs_active); end
    n_checks++; if (obs_done != 1) begin n_errors++; $display("FAIL noflush_done: got %0d pulses expected 1", obs_done); end
  endtask

  task automatic test_busy_drain;
    int es;
    es = model_switch(1'b0, 4, '0, 0);
    run_switch(1'b1, 1'b0, 4, '0, 0, 1'b0);
    n_checks++; if (obs_stall != es) begin n_errors++; $display("FAIL busy_stall: got %0d cycles expected %0d", obs_stall, es); end
    n_checks++; if (obs_wb.size() != 0) begin n_errors++; $display("FAIL busy_wbreq: got %0d requests expected 0", obs_wb.size()); end
    n_checks++; if (obs_active !== 1'b1) begin n_errors++; $display("FAIL busy_same_bank_active: got %0d expected 1", obs_active); end
  endtask

  task automatic test_flush_dirty;
    int es;
    logic bad;
    es = model_switch(1'b1, 0, 8'h24, 3);
    run_switch(1'b0, 1'b1, 0, 8'h24, 3, 1'b0);
    model_active = 0;
    bad = (obs_wb.size() != exp_wb.size());
    for (int i = 0; i < exp_wb.size() && !bad; i++) if (obs_wb[i] != exp_wb[i]) bad = 1'b1;
    n_checks++; if (bad) begin n_errors++; $display("FAIL dirty_wb_seq: got %0d requests (first %0d) expected 2 (2 then 5)", obs_wb.size(), (obs_wb.size() > 0) ? obs_wb[0] : -1); end
    n_checks++; if (obs_unstable != 0) begin n_errors++; $display("FAIL dirty_idx_stable: got %0d moves expected 0", obs_unstable); end
    n_checks++; if (obs_stall != es) begin n_errors++; $display("FAIL dirty_stall: got %0d cycles expected %0d", obs_stall, es); end
    n_checks++; if (obs_inval != 1 || obs_bad_bank != 0) begin n_errors++; $display("FAIL dirty_inval: got %0d pulses (%0d wrong bank) expected 1", obs_inval, obs_bad_bank); end
    n_checks++; if (obs_active !== 1'b0 || obs_done != 1) begin n_errors++; $display("FAIL dirty_switch: got active %0d done %0d expected 0 1", obs_active, obs_done); end
  endtask

  task automatic test_flush_clean;
    int es;
    es = model_switch(1'b1, 0, '0, 0);
    run_switch(1'b1, 1'b1, 0, '0, 0, 1'b0);
    model_active = 1;
    n_checks++; if (obs_stall != es) begin n_errors++; $display("FAIL clean_stall: got %0d cycles expected %0d", obs_stall, es); end
    n_checks++; if (obs_wb.size() != 0 || obs_inval != 1) begin n_errors++; $display("FAIL clean_seq: got wb %0d inval %0d expected 0 1", obs_wb.size(), obs_inval); end
    n_checks++; if (obs_active !== 1'b1) begin n_errors++; $display("FAIL clean_active: got %0d expected 1", obs_active); end
  endtask

  task automatic test_random;
    logic bank, flush, spur, bad;
    logic [NUM_LINES-1:0] d;
    int busy_n, ackd, es;
    for (int it = 0; it < 16; it++) begin
      bank   = 1'($urandom_range(0, 1));
      flush  = 1'($urandom_range(0, 1));
      spur   = 1'($urandom_range(0, 1));
      busy_n = $urandom_range(0, 3);
      ackd   = $urandom_range(0, 3);
      d      = NUM_LINES'($urandom);
      es     = model_switch(flush, busy_n, d, ackd);
      run_switch(bank, flush, busy_n, d, ackd, spur);
      model_active = int'(bank);
      bad = (obs_wb.size() != exp_wb.size());
      for (int i = 0; i < exp_wb.size() && !bad; i++) if (obs_wb[i] != exp_wb[i]) bad = 1'b1;
      n_checks++; if (obs_timeout != 0) begin n_errors++; $display("FAIL rnd%0d_timeout: stall still high after 300 cycles", it); end
      n_checks++; if (obs_stall != es) begin n_errors++; $display("FAIL rnd%0d_stall: got %0d cycles expected %0d", it, obs_stall, es); end
      n_checks++; if (bad || obs_unstable != 0) begin n_errors++; $display("FAIL rnd%0d_wb: got %0d requests (%0d unstable) expected %0d", it, obs_wb.size(), obs_unstable, exp_wb.size()); end
      n_checks++; if (obs_inval != int'(flush) || obs_bad_bank != 0) begin n_errors++; $display("FAIL rnd%0d_inval: got %0d expected %0d", it, obs_inval, flush); end
      n_checks++; if (obs_done != 1 || int'(obs_active) != model_active) begin n_errors++; $display("FAIL rnd%0d_switch: got done %0d active %0d expected 1 %0d", it, obs_done, obs_active, model_active); end
    end
  endtask

  task automatic test_bad_target;
    int dones;
    dones = 0;
    @(posedge clk); #1;
    b.switch_cache_w = 1'b1; b.switch_bank = 2'd2; b.switch_flush = 1'b0;
    @(negedge clk);
    n_checks++; if (b.stall !== 1'b1) begin n_errors++; $display("FAIL bt_legal_stall: got %0b expected 1", b.stall); end
    @(posedge clk); #1 b.switch_cache_w = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (b.active_bank !== 2'd2 || b.stall !== 1'b0) begin n_errors++; $display("FAIL bt_legal_switch: got active %0d stall %0b expected 2 0", b.active_bank, b.stall); end
    @(posedge clk); #1;
    b.switch_cache_w = 1'b1; b.switch_bank = 2'd3;
    @(negedge clk);
    n_checks++; if (b.stall !== 1'b0 || b.bad_target !== 1'b0) begin n_errors++; $display("FAIL bt_req_cycle: got stall %0b bad %0b expected 0 0", b.stall, b.bad_target); end
    @(posedge clk); #1 b.switch_cache_w = 1'b0;
    @(negedge clk);
    n_checks++; if (b.bad_target !== 1'b1 || b.stall !== 1'b0) begin n_errors++; $display("FAIL bt_pulse: got bad %0b stall %0b expected 1 0", b.bad_target, b.stall); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (b.switch_done) dones++;
      n_checks++; if (b.bad_target !== 1'b0 || b.stall !== 1'b0) begin n_errors++; $display("FAIL bt_after%0d: got bad %0b stall %0b expected 0 0", i, b.bad_target, b.stall); end
    end
    n_checks++; if (b.active_bank !== 2'd2 || dones != 0) begin n_errors++; $display("FAIL bt_unchanged: got active %0d done %0d expected 2 0", b.active_bank, dones); end
  endtask

  task automatic test_reset_mid_wb;
    logic reached;
    reached = 1'b0;
    run_switch(1'b1, 1'b0, 0, '0, 0, 1'b0);
    dirty_a = 8'h08;
    @(posedge clk); #1;
    a.switch_cache_w = 1'b1; a.switch_bank = 1'b0; a.switch_flush = 1'b1;
    for (int i = 0; i < 30 && !reached; i++) begin
      @(posedge clk); #1;
      a.switch_cache_w = 1'b0;
      reached = a.wb_req;
    end
    n_checks++; if (!reached || a.scan_idx !== 3'd3) begin n_errors++; $display("FAIL rst_reach_wb: got wb_req %0b idx %0d expected 1 3", reached, a.scan_idx); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; a.wb_ack = 1'b1;
    @(negedge clk);
    n_checks++; if ({a.wb_req, a.stall, a.active_bank, a.scan_idx} !== 6'b0) begin n_errors++; $display("FAIL rst_idle: got wb %0b stall %0b active %0d idx %0d expected 0 0 0 0", a.wb_req, a.stall, a.active_bank, a.scan_idx); end
    @(posedge clk); #1 a.wb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if ({a.wb_req, a.stall, a.inval_bank, a.switch_done} !== 4'b0) begin n_errors++; $display("FAIL rst_late_ack%0d: got %b expected 0000", i, {a.wb_req, a.stall, a.inval_bank, a.switch_done}); end
    end
    model_active = 0;
  endtask

  initial begin
    a.switch_cache_w = 1'b0; a.switch_bank = '0; a.switch_flush = 1'b0;
    a.cache_busy = 1'b0; a.wb_ack = 1'b0;
    b.switch_cache_w = 1'b0; b.switch_bank = '0; b.switch_flush = 1'b0;
    b.cache_busy = 1'b0; b.wb_ack = 1'b0;
    test_reset();
    test_no_flush();
    test_busy_drain();
    test_flush_dirty();
    test_flush_clean();
    test_random();
    test_bad_target();
    test_reset_mid_wb();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
